// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared widths, defaults and fetch FSM encoding for the fetcher slice
package fetcher_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam int IQ_DEPTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetcher_iq.sv
// fetcher_iq: circular instruction queue of {instr, pc}; head reads zero when empty
module fetcher_iq import fetcher_pkg::*; #(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int PTR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din_instr,
  input  logic [DATA_WIDTH-1:0] din_pc,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [DATA_WIDTH-1:0] head_pc,
  output logic [PTR_W:0]        count,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem [DEPTH];
  logic [PTR_W-1:0] hd, tl;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_push = en && push && !clear;
  assign do_pop = en && pop && !empty && !clear;
  assign head_instr = empty ? ZERO_DATA : instr_mem[hd];
  assign head_pc = empty ? ZERO_DATA : pc_mem[hd];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else if (en && clear) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else begin
      hd <= hd + PTR_W'(do_pop);
      tl <= tl + PTR_W'(do_push);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) begin
      instr_mem[tl] <= din_instr;
      pc_mem[tl] <= din_pc;
    end
endmodule

// File: rtl/fetcher.sv
// fetcher: PC, fetch FSM and memory handshake feeding the instruction queue
module fetcher import fetcher_pkg::*; #(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int IQ_PTR_W = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = ZERO_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_done,
  input  logic [31:0] in_mem_instr,
  input  logic        in_dispatch_ready,
  output logic [31:0] out_decode_instr,
  output logic [31:0] out_decode_pc,
  output logic        out_decode_valid,
  input  logic        in_rob_flush,
  input  logic [31:0] in_rob_target
);
  localparam logic [IQ_PTR_W:0] FULL_CNT = (IQ_PTR_W+1)'(IQ_DEPTH);
  fetch_state_t state, state_nx;
  logic [31:0] pc, pc_nx, addr_nx;
  logic req_nx, issue, push, empty;
  logic [IQ_PTR_W:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      out_mem_req <= 1'b0;
      out_mem_addr <= '0;
    end else if (rdy) begin
      state <= state_nx;
      pc <= pc_nx;
      out_mem_req <= req_nx;
      out_mem_addr <= addr_nx;
    end
  // a request only leaves IDLE while a queue slot is free, so its word always has room
  always_comb begin
    issue = state == IDLE && !in_rob_flush && count < FULL_CNT;
    state_nx = issue ? WAIT :
               state == WAIT && !in_mem_done ? (in_rob_flush ? DISCARD : WAIT) :
               state == DISCARD && !in_mem_done ? DISCARD : IDLE;
  end
  // in WAIT/DISCARD the pc register doubles as the latched flush target
  always_comb begin
    push = state == WAIT && in_mem_done && !in_rob_flush;
    pc_nx = in_rob_flush ? in_rob_target : push ? pc + 32'd4 : pc;
    req_nx = state_nx == WAIT;
    addr_nx = issue ? {pc[31:2], 2'b00} : out_mem_addr;
  end
  fetcher_iq #(.DEPTH(IQ_DEPTH), .PTR_W(IQ_PTR_W)) u_iq (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .push(push),
    .pop(in_dispatch_ready),
    .clear(in_rob_flush),
    .din_instr(in_mem_instr),
    .din_pc(pc),
    .head_instr(out_decode_instr),
    .head_pc(out_decode_pc),
    .count(count),
    .empty(empty)
  );
  assign out_decode_valid = !empty;
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: randomized scoreboard bench with a behavioural memory and queue model
module tb_fetcher;
  logic clk = 0, rst = 1, rdy = 0, out_mem_req, in_mem_done = 0, in_dispatch_ready = 0;
  logic out_decode_valid, in_rob_flush = 0;
  logic [31:0] out_mem_addr, in_mem_instr = 0, out_decode_instr, out_decode_pc, in_rob_target = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t exp_q[$];
  logic [31:0] next_pc = 0;
  bit push_pend = 0, mem_busy = 0, stale = 0, got_req = 0;
  int lat = 0;

  fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_done(in_mem_done), .in_mem_instr(in_mem_instr),
    .in_dispatch_ready(in_dispatch_ready),
    .out_decode_instr(out_decode_instr), .out_decode_pc(out_decode_pc),
    .out_decode_valid(out_decode_valid),
    .in_rob_flush(in_rob_flush), .in_rob_target(in_rob_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: compares the presented head against the scoreboard and retires pops/flushes
  always @(negedge clk) begin
    int n;
    if (rst) begin
      n = exp_q.size() - int'(push_pend);
      chk("valid", {31'd0, out_decode_valid}, {31'd0, n > 0});
      if (n > 0) begin
        chk("head_instr", out_decode_instr, exp_q[0].instr);
        chk("head_pc", out_decode_pc, exp_q[0].pc);
      end else begin
        chk("empty_instr", out_decode_instr, 32'h0);
        chk("empty_pc", out_decode_pc, 32'h0);
      end
      if (rdy && in_rob_flush) exp_q.delete();
      else if (rdy && in_dispatch_ready && n > 0) void'(exp_q.pop_front());
    end
  end

  function automatic logic [31:0] pick_target();
    int s = $urandom_range(0, 3);
    return s == 0 ? 32'h0000_1000 : s == 1 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
  endfunction

  // one cycle of stimulus: memory model, random inputs, expected pushes and PC tracking
  task automatic step(input int rp, input int dp, input int fp);
    @(posedge clk);
    #1;
    push_pend = 0;
    if (rst && out_mem_req && !mem_busy) begin
      chk("req_addr", out_mem_addr, {next_pc[31:2], 2'b00});
      chk("req_room", {31'd0, exp_q.size() < 16}, 32'd1);
      mem_busy = 1;
      stale = 0;
      lat = $urandom_range(0, 3);
      got_req = 1;
    end
    rdy = $urandom_range(0, 99) < rp;
    in_dispatch_ready = $urandom_range(0, 99) < dp;
    in_rob_flush = rdy && ($urandom_range(0, 99) < fp);
    in_rob_target = pick_target();
    in_mem_done = 0;
    if (mem_busy && rdy) begin
      if (lat == 0) begin
        in_mem_done = 1;
        in_mem_instr = $urandom;
        mem_busy = 0;
        if (!in_rob_flush && !stale) begin
          exp_q.push_back('{in_mem_instr, next_pc});
          push_pend = 1;
          next_pc = next_pc + 32'd4;
        end
      end else lat--;
    end
    if (in_rob_flush) begin
      next_pc = in_rob_target;
      if (mem_busy) stale = 1;
    end
  endtask

  initial begin
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, out_mem_req}, 32'd0);
    chk("rst_addr", out_mem_addr, 32'h0);
    chk("rst_valid", {31'd0, out_decode_valid}, 32'd0);
    chk("rst_instr", out_decode_instr, 32'h0);
    chk("rst_pc", out_decode_pc, 32'h0);
    rst = 1;
    repeat (200) step(100, 0, 0);
    chk("full_count", exp_q.size(), 32'd16);
    chk("full_noreq", {31'd0, out_mem_req}, 32'd0);
    step(100, 100, 0);
    got_req = 0;
    for (int i = 0; i < 10 && !got_req; i++) step(100, 0, 0);
    chk("req_after_pop", {31'd0, got_req}, 32'd1);
    repeat (3000) step(85, 50, 3);
    repeat (2000) step(90, 70, 15);
    for (int i = 0; i < 50 && !out_mem_req; i++) step(100, 50, 0);
    chk("reset_setup", {31'd0, out_mem_req}, 32'd1);
    #2 rst = 0;
    #1;
    chk("async_req", {31'd0, out_mem_req}, 32'd0);
    chk("async_addr", out_mem_addr, 32'h0);
    chk("async_valid", {31'd0, out_decode_valid}, 32'd0);
    chk("async_instr", out_decode_instr, 32'h0);
    exp_q.delete();
    next_pc = 0;
    mem_busy = 0;
    stale = 0;
    push_pend = 0;
    in_mem_done = 0;
    in_rob_flush = 0;
    @(negedge clk);
    #2 rst = 1;
    got_req = 0;
    repeat (500) step(90, 60, 5);
    chk("restart_req", {31'd0, got_req}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
